pctrl_gen: RTL and testbench
============================

Name: pctrl_gen

Overview:
- Parametrised successor of the serial packet controller. Sits on the shared serial command line `rx`, alongside the datapath it drives through `opcode`.
- Receives frames on `rx` with configurable bit time, address width and opcode width, and matches its node address or a broadcast address.
- Decodes the opcode and holds it, or pulses it, for a per-opcode execute window.
- Reports framing errors and a busy status.

Parameters:
- ADDR_W, 8, address field width in bits.
- OP_W, 3, opcode field width in bits.
- BIT_CYCLES, 4, clk cycles per serial bit; must be >= 2.
- EXEC_LONG, 127, execute length minus 1 for OUT_RES and OUT_RES_ADD.
- EXEC_SHORT, 31, execute length minus 1 for all other opcodes.
- SKIP_GAP, 50, extra idle cycles after skipping a frame addressed to another node.
- BCAST_ADDR, all-ones (ADDR_W bits), address that every node accepts.

Ports:
- clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- address  in  ADDR_W  node address; sampled at address compare.
- rx  in  1  serial line; idles high; already synchronised upstream.
- opcode  out  OP_W  current command; NO_OP when idle.
- op_valid  out  1  one-cycle pulse on the first EXECUTE cycle.
- busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse on a stop-bit or parity failure.

Behaviour:
- Reset: all state is synchronous, active-high on `Rst`; reset mid-frame aborts the frame.
  - opcode = NO_OP (all ones), op_valid = 0, busy = 0, frame_err = 0, state = IDLE, counters and shifter = 0.
- Frame format, in order:
  - start bit (0);
  - ADDR_W address bits, LSB first;
  - OP_W opcode bits, LSB first;
  - [parity bit];
  - stop bit (1).
- Bit sampling:
  - Each bit is sampled at mid-bit, cycle floor(BIT_CYCLES/2) of the bit.
  - Subsequent samples are every BIT_CYCLES cycles.
- States: IDLE, START, ADDR, OP, STOP, EXECUTE, SKIP.
- IDLE: when rx = 0, go to START and start the bit timer.
- START: at mid-bit, if rx = 1 it is a false start, return to IDLE with no error; else go to ADDR.
- ADDR: shift in ADDR_W bits. After the last sample:
  - shifter == address or shifter == BCAST_ADDR: go to OP;
  - otherwise: go to SKIP.
- SKIP: ignore rx for the rest of the frame, i.e. (OP_W + 1 + parity) bit periods, plus SKIP_GAP cycles, then go to IDLE. No outputs change.
- OP: shift in OP_W bits (plus parity if enabled), then go to STOP.
- STOP, at mid-bit:
  - rx = 0: pulse frame_err, discard the opcode, go to SKIP with a zero remaining-bits count (SKIP_GAP only).
  - rx = 1: go to EXECUTE next cycle. Load exec_cnt = EXEC_LONG for OUT_RES or OUT_RES_ADD, else EXEC_SHORT.
- EXECUTE:
  - On the first cycle, opcode = the decoded value and op_valid = 1.
  - MUL and MUL_ADD are pulse ops: opcode returns to NO_OP after 1 cycle.
  - Other opcodes hold until exec_cnt reaches 0.
  - exec_cnt decrements once per cycle, so the window is exec_cnt + 1 cycles.
  - At 0: opcode = NO_OP, go to IDLE.
  - rx is ignored; a start bit arriving during EXECUTE is not captured.
- A decoded NO_OP still runs EXECUTE for EXEC_SHORT+1 cycles with opcode = NO_OP and op_valid pulsing.
- busy = 1 from the START entry cycle through the last EXECUTE/SKIP cycle.
- Counters are sized for the largest of EXEC_LONG, SKIP_GAP and BIT_CYCLES, and do not wrap.

Optional Feature:
- Macro: PCTRL_PARITY_EN.
- Defined:
  - One even-parity bit follows the opcode; it covers the address and opcode bits.
  - On mismatch at the parity sample: pulse frame_err, discard the frame, go to SKIP covering the remaining stop bit plus SKIP_GAP.
- Undefined: no parity bit in the frame; the frame is one bit shorter.

Decomposition:
- Package pctrl_pkg holds:
  - opcode constants OUT_DATA1 = 0, OUT_DATA2 = 1, OUT_RES = 2, OUT_RES_ADD = 3, LOAD_RES = 4, MUL = 5, MUL_ADD = 6, NO_OP = 7;
  - the state enumeration;
  - a helper function that returns the exec length for an opcode.
- Sub-module pctrl_bit_timer (parameter BIT_CYCLES):
  - inputs clk, Rst, start, stop;
  - output `sample`, a one-cycle strobe at mid-bit and then every BIT_CYCLES cycles.

Test Plan (all tests use BIT_CYCLES = 4, address = 8'h5A):
- Frame addr 5A, op 2 (OUT_RES) -> op_valid pulses once; opcode = 2 for exactly 128 cycles, then 7; busy drops the next cycle.
- Frame addr 5A, op 5 (MUL) -> opcode = 5 for exactly 1 cycle, NO_OP for the next 31 cycles, then IDLE.
- Frame addr 3C, op 2 -> opcode stays 7, busy stays high through the remaining 4 bit periods (16 cycles) plus 50 cycles, and a second frame sent inside that window is ignored.
- Frame addr FF (broadcast), op 4 -> accepted; opcode = 4 for 32 cycles.
- rx low for 1 cycle only (glitch) -> false start, busy for under 4 cycles, no frame_err. Stop bit forced to 0 -> frame_err pulses once, opcode stays 7.
- Rst asserted mid-EXECUTE with op 3 -> the next cycle shows opcode = 7, busy = 0; a clean frame afterwards decodes normally. With PCTRL_PARITY_EN, a wrong parity bit -> frame_err pulses, no op_valid.

Source files
------------

// File: rtl/pctrl_pkg.sv
// pctrl_pkg
// Shared definitions for the serial packet controller (pctrl_gen).
//   - opcode numbering used on the command line and on the opcode output
//   - FSM state enumeration
//   - helpers: execute-window length per opcode, pulse-op test, integer max
package pctrl_pkg;

  localparam int OUT_DATA1   = 0;
  localparam int OUT_DATA2   = 1;
  localparam int OUT_RES     = 2;
  localparam int OUT_RES_ADD = 3;
  localparam int LOAD_RES    = 4;
  localparam int MUL         = 5;
  localparam int MUL_ADD     = 6;
  localparam int NO_OP       = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    OP,
    STOP,
    EXECUTE,
    SKIP
  } state_e;

  // Execute window length minus one for a decoded opcode.
  function automatic int exec_len(input int op, input int long_len, input int short_len);
    if (op == OUT_RES || op == OUT_RES_ADD) begin
      return long_len;
    end
    return short_len;
  endfunction

  // Pulse ops drive the opcode for a single cycle only.
  function automatic logic is_pulse_op(input int op);
    return (op == MUL) || (op == MUL_ADD);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pctrl_bit_timer.sv
// pctrl_bit_timer
// Bit-period timer for the serial receiver. After 'start' it emits a
// one-cycle 'sample' strobe floor(BIT_CYCLES/2) cycles later (the start
// cycle counts as cycle 0), then every BIT_CYCLES cycles until 'stop'.
// Ports:
//   clk     in  system clock
//   Rst     in  synchronous active-high reset
//   start   in  (re)arm the timer; wins over stop
//   stop    in  halt and clear the timer
//   sample  out mid-bit strobe
module pctrl_bit_timer
  import pctrl_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic Rst,
  input  logic start,
  input  logic stop,
  output logic sample
);

  localparam int HALF = BIT_CYCLES / 2;
  localparam int TW   = max_int($clog2(BIT_CYCLES), 1);

  logic [TW-1:0] cnt;
  logic          running;

  // Countdown to the next sample point; reloaded with a full bit period
  // each time it expires.
  always_ff @(posedge clk) begin
    if (Rst) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= TW'(HALF - 1);
    end else if (stop) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (running) begin
      if (cnt == '0) begin
        cnt <= TW'(BIT_CYCLES - 1);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign sample = running && (cnt == '0);

endmodule

// File: rtl/pctrl_gen.sv
// pctrl_gen
// Parametrised serial packet controller. Receives frames on 'rx'
// (start, address LSB first, opcode LSB first, optional even parity, stop),
// accepts its own node address or the broadcast address, and drives the
// decoded opcode for an execute window.
// Optional feature macro: PCTRL_PARITY_EN (even parity bit after the opcode,
// covering address and opcode bits).
// Ports:
//   clk        in   system clock
//   Rst        in   synchronous active-high reset
//   address    in   node address (ADDR_W)
//   rx         in   serial line, idles high, already synchronised
//   opcode     out  current command (OP_W), all ones (NO_OP) when idle
//   op_valid   out  one-cycle pulse on the first EXECUTE cycle
//   busy       out  high whenever the FSM is not in IDLE
//   frame_err  out  one-cycle pulse on stop-bit or parity failure
module pctrl_gen
  import pctrl_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                OP_W       = 3,
  parameter int                BIT_CYCLES = 4,
  parameter int                EXEC_LONG  = 127,
  parameter int                EXEC_SHORT = 31,
  parameter int                SKIP_GAP   = 50,
  parameter logic [ADDR_W-1:0] BCAST_ADDR = '1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rx,
  output logic [OP_W-1:0]   opcode,
  output logic              op_valid,
  output logic              busy,
  output logic              frame_err
);

`ifdef PCTRL_PARITY_EN
  localparam int PAR_BITS      = 1;
  localparam int SKIP_PAR_LOAD = BIT_CYCLES + SKIP_GAP - 1;
`else
  localparam int PAR_BITS      = 0;
`endif

  // A skipped frame covers the opcode bits, optional parity and stop bit.
  localparam int SKIP_ADDR_CYC  = (OP_W + 1 + PAR_BITS) * BIT_CYCLES + SKIP_GAP;
  localparam int SKIP_STOP_LOAD = (SKIP_GAP > 0) ? SKIP_GAP - 1 : 0;
  localparam int CNT_MAX = max_int(max_int(EXEC_LONG, EXEC_SHORT),
                                   max_int(SKIP_ADDR_CYC, BIT_CYCLES));
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int BCNT_W = $clog2(ADDR_W + OP_W + 1);
  localparam logic [OP_W-1:0] NO_OP_V = '1;

  state_e              state, state_n;
  logic [ADDR_W-1:0]   addr_shift, addr_shift_n, addr_in;
  logic [OP_W-1:0]     op_shift, op_shift_n, op_in;
  logic [OP_W-1:0]     op_reg, op_reg_n;
  logic [BCNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                par, par_n;
  logic                first, first_n;
  logic                err, err_n;
  logic                sample, timer_start, timer_stop;

  assign timer_start = (state == IDLE) && !rx;
  assign timer_stop  = (state == IDLE) || (state == EXECUTE) || (state == SKIP);

  pctrl_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk   (clk),
    .Rst   (Rst),
    .start (timer_start),
    .stop  (timer_stop),
    .sample(sample)
  );

  // LSB-first shift: the new bit enters at the top and moves down.
  assign addr_in = (addr_shift >> 1) | (ADDR_W'(rx) << (ADDR_W - 1));
  assign op_in   = (op_shift >> 1) | (OP_W'(rx) << (OP_W - 1));

  always_ff @(posedge clk) begin
    if (Rst) begin
      state      <= IDLE;
      addr_shift <= '0;
      op_shift   <= '0;
      op_reg     <= NO_OP_V;
      bit_cnt    <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      first      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      addr_shift <= addr_shift_n;
      op_shift   <= op_shift_n;
      op_reg     <= op_reg_n;
      bit_cnt    <= bit_cnt_n;
      cnt        <= cnt_n;
      par        <= par_n;
      first      <= first_n;
      err        <= err_n;
    end
  end

  // Next-state and datapath updates. 'cnt' times both the execute window
  // and the skip period; it only counts down, so it never wraps.
  always_comb begin
    state_n      = state;
    addr_shift_n = addr_shift;
    op_shift_n   = op_shift;
    op_reg_n     = op_reg;
    bit_cnt_n    = bit_cnt;
    cnt_n        = cnt;
    par_n        = par;
    first_n      = 1'b0;
    err_n        = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) begin
          state_n      = START;
          addr_shift_n = '0;
          op_shift_n   = '0;
          bit_cnt_n    = '0;
          par_n        = 1'b0;
        end
      end
      START: begin
        if (sample) begin
          state_n = rx ? IDLE : ADDR;
        end
      end
      ADDR: begin
        if (sample) begin
          addr_shift_n = addr_in;
          par_n        = par ^ rx;
          if (bit_cnt == BCNT_W'(ADDR_W - 1)) begin
            bit_cnt_n = '0;
            if (addr_in == address || addr_in == BCAST_ADDR) begin
              state_n = OP;
            end else begin
              state_n = SKIP;
              cnt_n   = CNT_W'(SKIP_ADDR_CYC - 1);
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      OP: begin
        if (sample) begin
          if (bit_cnt < BCNT_W'(OP_W)) begin
            op_shift_n = op_in;
            par_n      = par ^ rx;
            bit_cnt_n  = bit_cnt + 1'b1;
`ifndef PCTRL_PARITY_EN
            if (bit_cnt == BCNT_W'(OP_W - 1)) begin
              state_n = STOP;
            end
`endif
          end
`ifdef PCTRL_PARITY_EN
          else if (rx != par) begin
            err_n   = 1'b1;
            state_n = SKIP;
            cnt_n   = CNT_W'(SKIP_PAR_LOAD);
          end else begin
            state_n = STOP;
          end
`endif
        end
      end
      STOP: begin
        if (sample) begin
          if (!rx) begin
            err_n   = 1'b1;
            state_n = SKIP;
            cnt_n   = CNT_W'(SKIP_STOP_LOAD);
          end else begin
            state_n  = EXECUTE;
            first_n  = 1'b1;
            op_reg_n = op_shift;
            cnt_n    = CNT_W'(exec_len(int'(op_shift), EXEC_LONG, EXEC_SHORT));
          end
        end
      end
      EXECUTE, SKIP: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pulse ops show their code only on the first execute cycle; all other
  // ops hold it for the whole window.
  assign opcode    = (state == EXECUTE && (first || !is_pulse_op(int'(op_reg)))) ? op_reg : NO_OP_V;
  assign op_valid  = first;
  assign busy      = (state != IDLE);
  assign frame_err = err;

endmodule

// File: tb/tb_pctrl_gen.sv
// tb_pctrl_gen
// Directed bench for pctrl_gen with BIT_CYCLES = 4 and node address 8'h5A.
// A negedge monitor accumulates per-scenario counts (op_valid pulses,
// frame_err pulses, busy cycles, execute cycles, cycles with a given opcode)
// that each scenario task compares against hand-computed values.
// Timing reference: the first cycle rx is seen low is cycle 0; the stop bit
// is sampled at cycle 50 (54 with PCTRL_PARITY_EN).
module tb_pctrl_gen;

`ifdef PCTRL_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int STOP_AT = 50 + 4 * PB;

  logic       clk;
  logic       Rst;
  logic [7:0] address;
  logic       rx;
  logic [2:0] opcode;
  logic       op_valid;
  logic       busy;
  logic       frame_err;

  int errors;
  int checks;

  int         n_valid, n_err, n_busy, n_active, n_match, n_exec;
  logic       in_exec;
  logic [2:0] watch_op, prev_op;
  int         rel_busy;

  pctrl_gen dut (
    .clk      (clk),
    .Rst      (Rst),
    .address  (address),
    .rx       (rx),
    .opcode   (opcode),
    .op_valid (op_valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle statistics, sampled mid-cycle.
  always @(negedge clk) begin
    if (op_valid) n_valid++;
    if (frame_err) n_err++;
    if (busy) n_busy++;
    if (opcode != 3'd7) n_active++;
    if (opcode == watch_op) n_match++;
    if (op_valid) in_exec = 1'b1;
    else if (!busy) in_exec = 1'b0;
    if (in_exec) n_exec++;
    if (prev_op != 3'd7 && opcode == 3'd7) rel_busy = int'(busy);
    prev_op = opcode;
  end

  task automatic clear_mon(input logic [2:0] w);
    n_valid  = 0;
    n_err    = 0;
    n_busy   = 0;
    n_active = 0;
    n_match  = 0;
    n_exec   = 0;
    in_exec  = 1'b0;
    rel_busy = -1;
    watch_op = w;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [2:0] o,
                            input logic bad_par, input logic bad_stop);
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(a[i]);
    for (int i = 0; i < 3; i++) send_bit(o[i]);
`ifdef PCTRL_PARITY_EN
    send_bit((^a) ^ (^o) ^ bad_par);
`else
    if (bad_par) $display("[TB] parity not built, bad_par ignored");
`endif
    send_bit(!bad_stop);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: busy still %b after %0d cycles, required 0", name, busy, k);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (opcode !== 3'd7) begin
      errors++; $display("[TB] FAIL reset_opcode: got %0d required 7", opcode);
    end
    checks++;
    if (op_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_op_valid: got %b required 0", op_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_frame_err: got %b required 0", frame_err);
    end
    Rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_out_res();
    @(posedge clk);
    clear_mon(3'd2);
    send_frame(8'h5A, 3'd2, 1'b0, 1'b0);
    wait_idle("out_res_idle", 400);
    checks++;
    if (n_valid !== 1) begin
      errors++; $display("[TB] FAIL out_res_valid: got %0d pulses required 1", n_valid);
    end
    checks++;
    if (n_match !== 128) begin
      errors++; $display("[TB] FAIL out_res_len: got %0d cycles required 128", n_match);
    end
    checks++;
    if (n_exec !== 128) begin
      errors++; $display("[TB] FAIL out_res_exec: got %0d cycles required 128", n_exec);
    end
    checks++;
    if (rel_busy !== 0) begin
      errors++; $display("[TB] FAIL out_res_release: busy at release %0d required 0", rel_busy);
    end
    checks++;
    if (n_busy !== STOP_AT + 128) begin
      errors++; $display("[TB] FAIL out_res_busy: got %0d cycles required %0d", n_busy, STOP_AT + 128);
    end
  endtask

  task automatic test_mul();
    @(posedge clk);
    clear_mon(3'd5);
    send_frame(8'h5A, 3'd5, 1'b0, 1'b0);
    wait_idle("mul_idle", 200);
    checks++;
    if (n_valid !== 1) begin
      errors++; $display("[TB] FAIL mul_valid: got %0d pulses required 1", n_valid);
    end
    checks++;
    if (n_match !== 1) begin
      errors++; $display("[TB] FAIL mul_pulse: got %0d cycles required 1", n_match);
    end
    checks++;
    if (n_exec !== 32) begin
      errors++; $display("[TB] FAIL mul_exec: got %0d cycles required 32", n_exec);
    end
    checks++;
    if (rel_busy !== 1) begin
      errors++; $display("[TB] FAIL mul_release: busy at release %0d required 1", rel_busy);
    end
  endtask

  task automatic test_skip();
    @(posedge clk);
    clear_mon(3'd4);
    // Second frame follows immediately and lands inside the skip window.
    send_frame(8'h3C, 3'd2, 1'b0, 1'b0);
    send_frame(8'h5A, 3'd4, 1'b0, 1'b0);
    wait_idle("skip_idle", 200);
    checks++;
    if (n_valid !== 0) begin
      errors++; $display("[TB] FAIL skip_valid: got %0d pulses required 0", n_valid);
    end
    checks++;
    if (n_active !== 0) begin
      errors++; $display("[TB] FAIL skip_opcode: %0d non-NO_OP cycles required 0", n_active);
    end
    checks++;
    if (n_busy !== 100 + 4 * PB) begin
      errors++; $display("[TB] FAIL skip_busy: got %0d cycles required %0d", n_busy, 100 + 4 * PB);
    end
    checks++;
    if (n_err !== 0) begin
      errors++; $display("[TB] FAIL skip_err: got %0d pulses required 0", n_err);
    end
  endtask

  task automatic test_bcast();
    @(posedge clk);
    clear_mon(3'd4);
    send_frame(8'hFF, 3'd4, 1'b0, 1'b0);
    wait_idle("bcast_idle", 200);
    checks++;
    if (n_valid !== 1) begin
      errors++; $display("[TB] FAIL bcast_valid: got %0d pulses required 1", n_valid);
    end
    checks++;
    if (n_match !== 32) begin
      errors++; $display("[TB] FAIL bcast_len: got %0d cycles required 32", n_match);
    end
  endtask

  task automatic test_false_start();
    @(posedge clk);
    clear_mon(3'd2);
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    wait_idle("glitch_idle", 20);
    checks++;
    if (n_busy !== 2) begin
      errors++; $display("[TB] FAIL glitch_busy: got %0d cycles required 2", n_busy);
    end
    checks++;
    if (n_err !== 0) begin
      errors++; $display("[TB] FAIL glitch_err: got %0d pulses required 0", n_err);
    end
  endtask

  task automatic test_stop_err();
    @(posedge clk);
    clear_mon(3'd2);
    send_frame(8'h5A, 3'd2, 1'b0, 1'b1);
    wait_idle("stop_err_idle", 200);
    checks++;
    if (n_err !== 1) begin
      errors++; $display("[TB] FAIL stop_err_pulse: got %0d pulses required 1", n_err);
    end
    checks++;
    if (n_valid !== 0 || n_active !== 0) begin
      errors++; $display("[TB] FAIL stop_err_op: valid %0d active %0d required 0 0", n_valid, n_active);
    end
    checks++;
    if (n_busy !== STOP_AT + 50) begin
      errors++; $display("[TB] FAIL stop_err_busy: got %0d cycles required %0d", n_busy, STOP_AT + 50);
    end
  endtask

  task automatic test_reset_mid_exec();
    @(posedge clk);
    clear_mon(3'd3);
    send_frame(8'h5A, 3'd3, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (opcode !== 3'd3) begin
      errors++; $display("[TB] FAIL mid_exec_opcode: got %0d required 3", opcode);
    end
    Rst = 1'b1;
    @(negedge clk);
    checks++;
    if (opcode !== 3'd7 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_exec_reset: opcode %0d busy %b required 7 0", opcode, busy);
    end
    Rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    clear_mon(3'd1);
    send_frame(8'h5A, 3'd1, 1'b0, 1'b0);
    wait_idle("after_reset_idle", 200);
    checks++;
    if (n_valid !== 1 || n_match !== 32) begin
      errors++; $display("[TB] FAIL after_reset_frame: valid %0d len %0d required 1 32", n_valid, n_match);
    end
  endtask

`ifdef PCTRL_PARITY_EN
  task automatic test_parity();
    @(posedge clk);
    clear_mon(3'd2);
    send_frame(8'h5A, 3'd2, 1'b1, 1'b0);
    wait_idle("parity_idle", 200);
    checks++;
    if (n_err !== 1) begin
      errors++; $display("[TB] FAIL parity_err: got %0d pulses required 1", n_err);
    end
    checks++;
    if (n_valid !== 0) begin
      errors++; $display("[TB] FAIL parity_valid: got %0d pulses required 0", n_valid);
    end
    checks++;
    if (n_busy !== 104) begin
      errors++; $display("[TB] FAIL parity_busy: got %0d cycles required 104", n_busy);
    end
  endtask
`endif

  initial begin
    errors   = 0;
    checks   = 0;
    address  = 8'h5A;
    prev_op  = 3'd7;
    clear_mon(3'd2);
    test_reset();
    test_out_res();
    test_mul();
    test_skip();
    test_bcast();
    test_false_start();
    test_stop_err();
    test_reset_mid_exec();
`ifdef PCTRL_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
